// File: rtl/pkt_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pkt_pkg : shared constants and types for the packet drain path   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package pkt_pkg;

   localparam int ID_W       = 32;
   localparam int NODE_W     = 16;
   localparam int PAYLOAD_W  = 128;
   localparam int DATA_W     = 32;
   localparam int BEATS      = 2 + PAYLOAD_W / DATA_W;
   localparam int PKT_W      = ID_W + 2 * NODE_W + PAYLOAD_W;
   localparam int BEAT_IDX_W = $clog2(BEATS);

   localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS - 1);

   // Field order puts the id in the MSBs so beats leave MSB-first.
   typedef struct packed {
      logic [ID_W-1:0]      id;
      logic [NODE_W-1:0]    src;
      logic [NODE_W-1:0]    dest;
      logic [PAYLOAD_W-1:0] payload;
   } pkt_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2
   } drain_state_e;

endpackage : pkt_pkg
`default_nettype wire

// File: rtl/pkt_beat_shifter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pkt_beat_shifter : holds one packet and presents it beat by beat |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module pkt_beat_shifter
   import pkt_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  pkt_t              pkt,
   input  logic              advance,
   output logic [DATA_W-1:0] data,
   output logic              first,
   output logic              last
);

   logic [PKT_W-1:0]      shreg;
   logic [BEAT_IDX_W-1:0] beat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg <= '0;
         beat  <= '0;
      end else if (load) begin
         shreg <= pkt;
         beat  <= '0;
      end else if (advance) begin
         shreg <= {shreg[PKT_W-DATA_W-1:0], {DATA_W{1'b0}}};
         beat  <= beat + BEAT_IDX_W'(1);
      end
   end

   assign data  = shreg[PKT_W-1 -: DATA_W];
   assign first = (beat == '0);
   assign last  = (beat == LAST_BEAT);

endmodule : pkt_beat_shifter
`default_nettype wire

// File: rtl/pkt_queue_drain.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pkt_queue_drain : pops packets and serialises them onto tx beats |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module pkt_queue_drain
   import pkt_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 q_empty,
   output logic                 q_pop,
   input  logic [ID_W-1:0]      q_id,
   input  logic [NODE_W-1:0]    q_src,
   input  logic [NODE_W-1:0]    q_dest,
   input  logic [PAYLOAD_W-1:0] q_payload,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic [DATA_W-1:0]    tx_data,
   output logic                 tx_sop,
   output logic                 tx_eop,
   output logic                 busy,
   output logic [31:0]          pkt_count
);

   drain_state_e      state;
   drain_state_e      state_nxt;
   pkt_t              head_pkt;
   logic [DATA_W-1:0] beat_data;
   logic              beat_first;
   logic              beat_last;
   logic              pop_ok;
   logic              advance;
   logic              last_xfer;

   assign head_pkt = '{id: q_id, src: q_src, dest: q_dest, payload: q_payload};

   // Gated by rst_n so no entry is popped (and lost) while held in reset.
   assign pop_ok    = rst_n && en && !q_empty;
   assign advance   = (state == SEND) && tx_ready;
   assign last_xfer = advance && beat_last;
   assign busy      = (state != IDLE);

   pkt_beat_shifter u_shifter (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (state == LOAD),
      .pkt     (head_pkt),
      .advance (advance),
      .data    (beat_data),
      .first   (beat_first),
      .last    (beat_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      q_pop     = 1'b0;
      tx_valid  = 1'b0;
      tx_data   = '0;
      tx_sop    = 1'b0;
      tx_eop    = 1'b0;
      case (state)
         IDLE: begin
            if (pop_ok) begin
               q_pop     = 1'b1;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            state_nxt = SEND;
         end
         SEND: begin
            tx_valid = 1'b1;
            tx_data  = beat_data;
            tx_sop   = beat_first;
            tx_eop   = beat_last;
            if (last_xfer) begin
               if (pop_ok) begin
                  q_pop     = 1'b1;
                  state_nxt = LOAD;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_count <= '0;
      end else if (last_xfer) begin
         pkt_count <= pkt_count + 32'd1;
      end
   end

endmodule : pkt_queue_drain
`default_nettype wire

// File: tb/tb_pkt_queue_drain.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pkt_queue_drain : directed bench with queue model/scoreboard  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_pkt_queue_drain;
   import pkt_pkg::*;

   logic                 clk;
   logic                 rst_n;
   logic                 en;
   logic                 q_empty;
   logic                 q_pop;
   logic [ID_W-1:0]      q_id      = '0;
   logic [NODE_W-1:0]    q_src     = '0;
   logic [NODE_W-1:0]    q_dest    = '0;
   logic [PAYLOAD_W-1:0] q_payload = '0;
   logic                 tx_valid;
   logic                 tx_ready;
   logic [DATA_W-1:0]    tx_data;
   logic                 tx_sop;
   logic                 tx_eop;
   logic                 busy;
   logic [31:0]          pkt_count;

   pkt_queue_drain dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .q_empty   (q_empty),
      .q_pop     (q_pop),
      .q_id      (q_id),
      .q_src     (q_src),
      .q_dest    (q_dest),
      .q_payload (q_payload),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .tx_data   (tx_data),
      .tx_sop    (tx_sop),
      .tx_eop    (tx_eop),
      .busy      (busy),
      .pkt_count (pkt_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
      end
   endtask

   // Queue model: pop sampled mid-cycle, head fields appear the cycle after.
   logic [ID_W-1:0]      mem_id   [2048];
   logic [NODE_W-1:0]    mem_src  [2048];
   logic [NODE_W-1:0]    mem_dest [2048];
   logic [PAYLOAD_W-1:0] mem_pay  [2048];
   int   wr = 0;
   int   rd = 0;
   logic pop_pending = 1'b0;

   assign q_empty = (rd == wr);

   always @(posedge clk) begin
      if (pop_pending) begin
         q_id      <= mem_id[rd % 2048];
         q_src     <= mem_src[rd % 2048];
         q_dest    <= mem_dest[rd % 2048];
         q_payload <= mem_pay[rd % 2048];
         rd        <= rd + 1;
      end
   end

   logic [33:0] exp_q[$];

   task automatic push(input logic [31:0] id, input logic [15:0] src,
                       input logic [15:0] dest, input logic [127:0] pay);
      logic [31:0] w;
      mem_id[wr % 2048]   = id;
      mem_src[wr % 2048]  = src;
      mem_dest[wr % 2048] = dest;
      mem_pay[wr % 2048]  = pay;
      wr++;
      for (int b = 0; b < 6; b++) begin
         case (b)
            0:       w = id;
            1:       w = {src, dest};
            default: w = pay[127 - 32*(b-2) -: 32];
         endcase
         exp_q.push_back({(b == 0), (b == 5), w});
      end
   endtask

   task automatic push_gen(input int id);
      logic [31:0] i;
      i = id;
      push(i, i[15:0] ^ 16'h1234, ~i[15:0],
           {i ^ 32'hA5A5_0000, i + 32'd1, ~i, i ^ 32'h0F0F_F0F0});
   endtask

   // Backpressure generator and monitor.
   logic ready_level = 1'b1;
   logic bp_mode     = 1'b0;
   always @(posedge clk) begin
      #1;
      tx_ready = bp_mode ? 1'($urandom_range(0, 1)) : ready_level;
   end

   int          cyc = 0;
   int          pops = 0;
   int          pop_empty = 0;
   int          beats_seen = 0;
   logic        tp_mode = 1'b0;
   logic        have_prev = 1'b0;
   int          last_sop = 0;
   logic        prev_stall = 1'b0;
   logic [33:0] prev_beat = '0;
   logic [33:0] e;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      pop_pending = q_pop;
      if (!rst_n) begin
         exp_q.delete();
         prev_stall = 1'b0;
      end else begin
         if (q_pop) begin
            pops++;
            if (q_empty) pop_empty++;
         end
         if (prev_stall)
            check("stall_hold", {tx_valid, tx_sop, tx_eop, tx_data}, {1'b1, prev_beat});
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
               check("extra_beat", {tx_sop, tx_eop, tx_data}, 34'h0);
            end else begin
               e = exp_q.pop_front();
               check("beat", {tx_sop, tx_eop, tx_data}, e);
            end
            beats_seen++;
            if (tx_sop) begin
               if (tp_mode && have_prev) check("sop_gap", cyc - last_sop, 7);
               last_sop  = cyc;
               have_prev = 1'b1;
            end
         end
         prev_stall = tx_valid && !tx_ready;
         prev_beat  = {tx_sop, tx_eop, tx_data};
         if (!tp_mode) have_prev = 1'b0;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_count(input string tag, input logic [31:0] target, input int budget);
      for (int i = 0; i < budget && pkt_count != target; i++) @(negedge clk);
      check(tag, pkt_count, target);
   endtask

   task automatic wait_beats(input string tag, input int target, input int budget);
      for (int i = 0; i < budget && beats_seen < target; i++) @(negedge clk);
      check(tag, beats_seen, target);
   endtask

   int   c0, c1, base_pops, base_beats;
   logic seen, any;

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      tick(3);
      check("rst_outputs", {q_pop, tx_valid, tx_sop, tx_eop, busy}, 5'b0);
      check("rst_data", tx_data, 0);
      check("rst_count", pkt_count, 0);
      rst_n = 1'b1;
      tick(2);

      // Empty queue, enabled
      en  = 1'b1;
      any = 1'b0;
      repeat (20) begin
         @(negedge clk);
         any = any | q_pop | tx_valid | busy;
      end
      check("empty_idle", any, 1'b0);

      // Single packet
      tick(1);
      push(32'd5, 16'h0003, 16'h0001, 128'h11112222_33334444_55556666_77778888);
      seen = 1'b0;
      c0 = 0;
      c1 = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (q_pop) begin seen = 1'b1; c0 = cyc; end
      end
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         if (tx_valid) begin seen = 1'b1; c1 = cyc; end
         else @(negedge clk);
      end
      check("latency", c1 - c0, 2);
      wait_count("single_count", 32'd1, 50);
      @(negedge clk);
      check("single_busy", busy, 1'b0);
      check("single_pops", pops, 1);

      // 1000 back-to-back packets
      tick(1);
      tp_mode = 1'b1;
      for (int i = 0; i < 1000; i++) push_gen(i);
      wait_count("burst_count", 32'd1001, 8000);
      tp_mode = 1'b0;
      check("burst_pops", pops, 1001);

      // Backpressure
      tick(1);
      bp_mode = 1'b1;
      for (int i = 0; i < 10; i++) push_gen(32'h1000 + i);
      wait_count("bp_count", 32'd1011, 2000);
      tick(1);
      bp_mode = 1'b0;

      // en dropped during beat 2
      en = 1'b0;
      tick(2);
      base_pops  = pops;
      base_beats = beats_seen;
      for (int i = 0; i < 3; i++) push_gen(32'h2000 + i);
      en = 1'b1;
      wait_beats("en_reach_beat2", base_beats + 2, 50);
      tick(1);
      en = 1'b0;
      wait_count("en_drop_count", 32'd1012, 100);
      tick(10);
      check("en_drop_busy", busy, 1'b0);
      check("en_drop_pops", pops - base_pops, 1);
      check("en_drop_left", q_empty, 1'b0);
      en = 1'b1;
      wait_count("en_resume_count", 32'd1014, 100);

      // Asynchronous reset during beat 3
      tick(2);
      base_beats = beats_seen;
      push_gen(32'h600);
      wait_beats("rst_reach_beat3", base_beats + 3, 50);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("async_rst_ctrl", {q_pop, tx_valid, tx_sop, tx_eop, busy}, 5'b0);
      check("async_rst_data", tx_data, 0);
      check("async_rst_count", pkt_count, 0);
      tick(2);
      rst_n = 1'b1;
      tick(1);
      push_gen(32'h700);
      wait_count("post_rst_count", 32'd1, 50);
      tick(3);

      check("pop_while_empty", pop_empty, 0);
      check("leftover_beats", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule : tb_pkt_queue_drain
`default_nettype wire

// File: doc/pkt_queue_drain.md
Name: pkt_queue_drain

Overview:
Reader/consumer end of the packet queue. Pops packets from the queue's pop/empty interface and serialises each one onto a 32-bit valid/ready beat stream: header beats first, then the payload. Sits between the packet queue and the downstream link/egress logic. Also provides a packet counter and a busy flag.

Parameters:
ID_W, 32, packet ID width.
NODE_W, 16, width of the src and dest node fields.
PAYLOAD_W, 128, payload width; must be a multiple of DATA_W.
DATA_W, 32, output beat width; ID_W and 2*NODE_W must each equal DATA_W.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  drain enable; when low, no new pop is issued
q_empty  in  1  queue empty flag
q_pop  out  1  pop strobe to the queue
q_id  in  ID_W  head packet ID; valid the cycle after a pop edge
q_src  in  NODE_W  head packet source node
q_dest  in  NODE_W  head packet destination node
q_payload  in  PAYLOAD_W  head packet payload
tx_valid  out  1  beat valid
tx_ready  in  1  downstream ready
tx_data  out  DATA_W  beat data
tx_sop  out  1  first beat of a packet
tx_eop  out  1  last beat of a packet
busy  out  1  high whenever state is not IDLE
pkt_count  out  32  count of fully transmitted packets

Behaviour:
- Beats per packet: BEATS = 2 + PAYLOAD_W/DATA_W (default 6).
- Beat order:
  - beat 0 = id
  - beat 1 = {src, dest}
  - beats 2..BEATS-1 = payload, most-significant word first
- Reset values: all outputs 0; state IDLE; beat index 0.
- Reset mid-packet: the packet is dropped and pkt_count is cleared. The popped entry is lost; this is by design.
- Queue contract: when q_pop is high at rising edge N, the q_* fields are valid throughout cycle N+1.
- FSM states: IDLE, LOAD, SEND.
  - IDLE: q_pop = en && !q_empty, combinational. If a pop occurs, next state is LOAD.
  - LOAD: one cycle. Capture q_id, q_src, q_dest and q_payload into the beat shift register. Beat index is set to 0. Next state is SEND. q_empty is ignored in LOAD.
  - SEND: tx_valid = 1. tx_data is the current beat. tx_sop = (beat == 0). tx_eop = (beat == BEATS-1).
    - A transfer happens when tx_valid && tx_ready; the beat index then increments.
    - While tx_valid && !tx_ready, tx_data, tx_sop and tx_eop hold stable.
  - On the last-beat transfer: pkt_count increments, wrapping at 2^32.
    - If en && !q_empty in that same cycle, q_pop is asserted combinationally and the next state is LOAD (back-to-back packets).
    - Otherwise the next state is IDLE.
- q_pop is never asserted in LOAD, or in SEND other than on a last-beat transfer. At most one pop per packet.
- Latency: pop at edge k, then LOAD in cycle k+1, then first tx_valid in cycle k+2.
- Throughput with tx_ready held high: BEATS+1 cycles per packet (7 at default).
- en deasserted mid-packet: the current packet completes; no further pop.
- en and q_empty are only sampled at pop decision points.
- tx_ready is ignored outside SEND. tx_valid never drops before the beat it carries has transferred.

Decomposition:
- Shared package pkt_pkg:
  - ID_W, NODE_W, PAYLOAD_W, DATA_W, BEATS constants
  - pkt_t struct {id, src, dest, payload}
  - drain_state_e enum {IDLE, LOAD, SEND}
- One natural sub-module, pkt_beat_shifter: loads a pkt_t, presents the current DATA_W beat, and shifts on an advance strobe; it outputs first/last flags.
- The FSM, pop logic and counter remain in pkt_queue_drain.

Test Plan:
- Single packet, tx_ready = 1: push id=5, src=0x0003, dest=0x0001, payload=0x11112222_33334444_55556666_77778888.
  - Expect exactly one q_pop.
  - Expect beats 0x5, 0x00030001, 0x11112222, 0x33334444, 0x55556666, 0x77778888.
  - sop on the first beat, eop on the sixth; pkt_count = 1; busy returns to 0.
- 1000 packets (id = 0..999) queued, tx_ready = 1, en = 1:
  - Beat-0 IDs arrive in order 0..999, back-to-back with 7 cycles per packet.
  - pkt_count = 1000; q_pop never asserted while q_empty = 1.
- Backpressure: toggle tx_ready pseudo-randomly (50%) across 10 packets.
  - tx_data, sop and eop stay stable while stalled.
  - No beats are lost or duplicated; pkt_count = 10.
- en dropped during beat 2 of packet 0, with 3 packets queued:
  - Packet 0 completes; no further pop; pkt_count = 1; state IDLE.
  - Raising en again drains the remaining 2 packets.
- Empty queue with en = 1 for 20 cycles: q_pop = 0, tx_valid = 0, busy = 0.
- rst_n asserted during beat 3:
  - All outputs go to 0 immediately (asynchronous).
  - After release, the next packet starts cleanly with sop and correct beat order; pkt_count restarts from 0.
